// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: state and cause encodings
// plus the counter width function used to size the internal counters.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_EXT = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } cause_e;

    // Bits needed to hold counts 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset deassertion synchronizer: asserts asynchronously with rst_n and
// releases srst_n after SYNC_STAGES rising edges of clk.
module rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic srst_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async assert, synchronized and stretched release, staggered
// per-group ar_out release, software reset. RST_SEQ_WDT_EN adds a watchdog.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned NUM_OUT        = 3,
    parameter int unsigned STEP_CYCLES    = 4,
    parameter int unsigned WDT_CYCLES     = 1024
) (
    input  logic               clk,
    input  logic               ar_n,
    input  logic               sw_rst,
`ifdef RST_SEQ_WDT_EN
    input  logic               wdt_kick,
`endif
    output logic [NUM_OUT-1:0] ar_out,
    output logic               rst_done,
    output logic [1:0]         state,
    output logic [1:0]         cause
);

    localparam int unsigned CNT_MAX = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    logic               srst_n;
    logic               wdt_expire;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [NUM_OUT-1:0] ar_out_q,   ar_out_d;
    logic               rst_done_q, rst_done_d;
    cause_e             cause_q,    cause_d;

    logic               int_rst;
    cause_e             int_cause;
    logic [NUM_OUT-1:0] ar_next;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk    (clk),
        .rst_n  (ar_n),
        .srst_n (srst_n)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WDT_W = cnt_width(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_q, wdt_d;

    always_comb begin
        wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_q == WDT_W'(WDT_CYCLES - 1));
        if ((state_q != RUN) || wdt_kick || wdt_expire) begin
            wdt_d = '0;
        end else begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge ar_n) begin
        if (!ar_n) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign wdt_expire = 1'b0;
`endif

    // Clearing the lowest still-set bit keeps release strictly in bit order.
    assign ar_next = ar_out_q & (ar_out_q << 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ar_out_d   = ar_out_q;
        rst_done_d = rst_done_q;
        cause_d    = cause_q;
        int_rst    = 1'b0;
        int_cause  = CAUSE_SW;

        if (state_q != HOLD) begin
            if (sw_rst) begin
                int_rst   = 1'b1;
                int_cause = CAUSE_SW;
            end else if (wdt_expire) begin
                int_rst   = 1'b1;
                int_cause = CAUSE_WDT;
            end
        end

        if (int_rst) begin
            state_d    = STRETCH;
            cnt_d      = '0;
            ar_out_d   = '1;
            rst_done_d = 1'b0;
            cause_d    = int_cause;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (srst_n) begin
                        state_d = STRETCH;
                        cnt_d   = '0;
                    end
                end
                STRETCH, RELEASE: begin
                    if (((state_q == STRETCH) && (cnt_q == CNT_W'(STRETCH_CYCLES - 1))) ||
                        ((state_q == RELEASE) && (cnt_q == CNT_W'(STEP_CYCLES - 1)))) begin
                        cnt_d    = '0;
                        ar_out_d = ar_next;
                        if (ar_next == '0) begin
                            state_d    = RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge ar_n) begin
        if (!ar_n) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            ar_out_q   <= '1;
            rst_done_q <= 1'b0;
            cause_q    <= CAUSE_EXT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ar_out_q   <= ar_out_d;
            rst_done_q <= rst_done_d;
            cause_q    <= cause_d;
        end
    end

    assign ar_out   = ar_out_q;
    assign rst_done = rst_done_q;
    assign state    = state_q;
    assign cause    = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: expected per-edge snapshots are queued
// from the release-timing formula and compared as the DUT advances.
module tb_rst_seq_ctrl;

    localparam int unsigned SYNC = 2;
    localparam int unsigned STR  = 16;
    localparam int unsigned N    = 3;
    localparam int unsigned STEP = 4;
`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WDT  = 8;
`else
    localparam int unsigned WDT  = 1024;
`endif
    // Edge (counted from ar_n rising) on which the sequencer enters STRETCH.
    localparam int BASE = SYNC + 1;

    typedef struct packed {
        logic [N-1:0] ar;
        logic         done;
        logic [1:0]   st;
        logic [1:0]   cause;
    } snap_t;

    logic         clk    = 1'b0;
    logic         ar_n   = 1'b0;
    logic         sw_rst = 1'b0;
`ifdef RST_SEQ_WDT_EN
    logic         wdt_kick = 1'b1;
`endif
    logic [N-1:0] ar_out;
    logic         rst_done;
    logic [1:0]   state;
    logic [1:0]   cause;

    int    checks = 0;
    int    passed = 0;
    snap_t exp_q[$];
    snap_t act;
    snap_t exp_s;

    rst_seq_ctrl #(
        .SYNC_STAGES    (SYNC),
        .STRETCH_CYCLES (STR),
        .NUM_OUT        (N),
        .STEP_CYCLES    (STEP),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk      (clk),
        .ar_n     (ar_n),
        .sw_rst   (sw_rst),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick (wdt_kick),
`endif
        .ar_out   (ar_out),
        .rst_done (rst_done),
        .state    (state),
        .cause    (cause)
    );

    always #5 clk = ~clk;

    always_comb act = {ar_out, rst_done, state, cause};

    // Expected outputs t edges after the edge that entered STRETCH (t<0: still HOLD).
    function automatic snap_t exp_at(input int t, input logic [1:0] c);
        snap_t s;
        s.cause = c;
        if (t < 0) begin
            s.ar = '1; s.done = 1'b0; s.st = 2'd0;
        end else if (t < int'(STR)) begin
            s.ar = '1; s.done = 1'b0; s.st = 2'd1;
        end else begin
            for (int i = 0; i < int'(N); i++) s.ar[i] = ((t - int'(STR)) < i * int'(STEP));
            s.done = (s.ar == '0);
            s.st   = s.done ? 2'd3 : 2'd2;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic power_cycle();
        ar_n = 1'b0;
        tick();
        tick();
        ar_n = 1'b1;
    endtask

    task automatic test_reset();
        ar_n = 1'b0;
        repeat (5) tick();
        checks++;
        if (act !== {{N{1'b1}}, 1'b0, 2'd0, 2'b00})
            $display("FAIL reset: ar/done/st/cause got %b want %b", act, {{N{1'b1}}, 1'b0, 2'd0, 2'b00});
        else passed++;
    endtask

    task automatic test_power_up();
        int e = 0;
        ar_n = 1'b1;
        for (int k = 1; k <= 30; k++) exp_q.push_back(exp_at(k - BASE, 2'b00));
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL power_up E%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
    endtask

    task automatic test_sw_run();
        int e = 0;
        sw_rst = 1'b1;
        for (int k = 0; k <= 28; k++) exp_q.push_back(exp_at(k, 2'b01));
        while (exp_q.size() > 0) begin
            tick();
            sw_rst = 1'b0;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL sw_run t=%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
            e++;
        end
    endtask

    task automatic test_async_mid();
        int e = 0;
        power_cycle();
        for (int k = 1; k <= 21; k++) exp_q.push_back(exp_at(k - BASE, 2'b00));
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL async_pre E%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
        ar_n = 1'b0;
        #1;
        checks++;
        if (act !== {{N{1'b1}}, 1'b0, 2'd0, 2'b00})
            $display("FAIL async_immediate: ar/done/st/cause got %b want %b", act, {{N{1'b1}}, 1'b0, 2'd0, 2'b00});
        else passed++;
        @(negedge clk);
        tick();
        ar_n = 1'b1;
        e = 0;
        for (int k = 1; k <= 30; k++) exp_q.push_back(exp_at(k - BASE, 2'b00));
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL async_repeat E%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
    endtask

    task automatic test_sw_hold();
        int e = 0;
        power_cycle();
        sw_rst = 1'b1;
        for (int k = 1; k <= 30; k++) exp_q.push_back(exp_at(k - BASE, 2'b00));
        while (exp_q.size() > 0) begin
            tick(); e++;
            if (e == 2) sw_rst = 1'b0;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL sw_hold E%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
    endtask

    task automatic test_sw_held_release();
        int e = 0;
        power_cycle();
        for (int k = 1; k <= 21; k++) exp_q.push_back(exp_at(k - BASE, 2'b00));
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL held_pre E%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
        sw_rst = 1'b1;
        for (int k = 0; k < 10; k++) exp_q.push_back(exp_at(0, 2'b01));
        e = 0;
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL held_sw cycle %0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
        sw_rst = 1'b0;
        for (int t = 1; t <= 28; t++) exp_q.push_back(exp_at(t, 2'b01));
        e = 0;
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL held_post t=%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
    endtask

`ifdef RST_SEQ_WDT_EN
    task automatic test_watchdog();
        int e = 0;
        wdt_kick = 1'b1;
        power_cycle();
        repeat (30) tick();
        for (int i = 0; i < 20; i++) begin
            wdt_kick = ((i % 5) == 0);
            tick();
            checks++;
            if (rst_done !== 1'b1) $display("FAIL wdt_kicked cycle %0d: rst_done got %b want 1", i, rst_done);
            else passed++;
        end
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        for (int k = 0; k < 7; k++) exp_q.push_back({{N{1'b0}}, 1'b1, 2'd3, 2'b00});
        exp_q.push_back(exp_at(0, 2'b10));
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL wdt_expire edge %0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
        wdt_kick = 1'b1;
        for (int t = 1; t <= 24; t++) exp_q.push_back(exp_at(t, 2'b10));
        e = 0;
        while (exp_q.size() > 0) begin
            tick(); e++;
            exp_s = exp_q.pop_front();
            checks++;
            if (act !== exp_s) $display("FAIL wdt_restart t=%0d: ar/done/st/cause got %b want %b", e, act, exp_s);
            else passed++;
        end
        wdt_kick = 1'b0;
        repeat (7) tick();
        wdt_kick = 1'b1;
        sw_rst   = 1'b1;
        tick();
        sw_rst   = 1'b0;
        checks++;
        if (act !== exp_at(0, 2'b01))
            $display("FAIL wdt_sw_same_cycle: ar/done/st/cause got %b want %b", act, exp_at(0, 2'b01));
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_sw_run();
        test_async_mid();
        test_sw_hold();
        test_sw_held_release();
`ifdef RST_SEQ_WDT_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached, checks %0d passed %0d", checks, passed);
        $fatal(1, "timeout");
    end

endmodule
